// File: rtl/operand_bit_streamer.sv
// Bit-serial reader for a WIDTH-bit operand: load once, then one bit per accepted next (LSB first; MSB first when MSB_FIRST_EN is defined).
// Latency: first bit is valid the cycle after load; stream_done pulses the cycle after the last next. Stalls indefinitely while next is low.
module operand_bit_streamer #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rest,
  input  logic [WIDTH-1:0] in_number,
  input  logic             load,
  input  logic             next,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [CNT_W-1:0] bits_left,
  output logic             stream_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;

`ifdef MSB_FIRST_EN
  assign shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
  assign bit_out   = bit_valid & shift_reg[WIDTH-1];
`else
  assign shift_nxt = {1'b0, shift_reg[WIDTH-1:1]};
  assign bit_out   = bit_valid & shift_reg[0];
`endif

  always_ff @(posedge clk) begin
    if (rest) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bits_left   <= '0;
      bit_valid   <= 1'b0;
      stream_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      stream_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load) begin
            state     <= STREAM;
            shift_reg <= in_number;
            bits_left <= CNT_W'(WIDTH);
            bit_valid <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        STREAM: begin
          // A load here aborts silently and wins over a simultaneous next.
          if (load) begin
            shift_reg <= in_number;
            bits_left <= CNT_W'(WIDTH);
          end else if (next) begin
            shift_reg <= shift_nxt;
            bits_left <= bits_left - CNT_W'(1);
            if (bits_left == CNT_W'(1)) begin
              state       <= DONE;
              bit_valid   <= 1'b0;
              busy        <= 1'b0;
              stream_done <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          bits_left <= '0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_bit_streamer.sv
module tb_operand_bit_streamer;

  localparam int W  = 8;
  localparam int BW = 1024;

  logic         clk = 1'b0;
  logic         rest;
  logic [W-1:0] in_number;
  logic         load;
  logic         next;
  logic         bit_out;
  logic         bit_valid;
  logic [3:0]   bits_left;
  logic         stream_done;
  logic         busy;

  logic [BW-1:0] b_in;
  logic          b_load;
  logic          b_next;
  logic          b_bit_out;
  logic          b_bit_valid;
  logic [10:0]   b_bits_left;
  logic          b_stream_done;
  logic          b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_bit_streamer #(.WIDTH(W)) dut (
    .clk(clk), .rest(rest), .in_number(in_number), .load(load), .next(next),
    .bit_out(bit_out), .bit_valid(bit_valid), .bits_left(bits_left),
    .stream_done(stream_done), .busy(busy)
  );

  operand_bit_streamer #(.WIDTH(BW)) dut_big (
    .clk(clk), .rest(rest), .in_number(b_in), .load(b_load), .next(b_next),
    .bit_out(b_bit_out), .bit_valid(b_bit_valid), .bits_left(b_bits_left),
    .stream_done(b_stream_done), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, "_left"},  32'(bits_left), 32'd0);
    chk({tag, "_done"},  32'(stream_done), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_bit"},   32'(bit_out), 32'd0);
  endtask

  initial begin
    logic [W-1:0] seq_b4;
    logic         exp_0f_first;
    logic [BW-1:0] big_op;
    int acc;
`ifdef MSB_FIRST_EN
    seq_b4       = 8'b0010_1101;
    exp_0f_first = 1'b0;
`else
    seq_b4       = 8'b1011_0100;
    exp_0f_first = 1'b1;
`endif
    rest = 1'b1; load = 1'b0; next = 1'b0; in_number = '0;
    b_in = '0; b_load = 1'b0; b_next = 1'b0;
    tick(); tick();
    chk_idle("reset");

    // Continuous stream of 8'hB4.
    rest = 1'b0; load = 1'b1; in_number = 8'hB4;
    tick();
    load = 1'b0; in_number = 8'h00;
    chk("b4_valid", 32'(bit_valid), 32'd1);
    chk("b4_busy", 32'(busy), 32'd1);
    next = 1'b1;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("b4_bit%0d", i), 32'(bit_out), 32'(seq_b4[i]));
      chk($sformatf("b4_left%0d", i), 32'(bits_left), 32'(W - i));
      chk($sformatf("b4_done%0d", i), 32'(stream_done), 32'd0);
      tick();
    end
    chk("b4_done_pulse", 32'(stream_done), 32'd1);
    chk("b4_done_valid", 32'(bit_valid), 32'd0);
    chk("b4_done_left", 32'(bits_left), 32'd0);
    next = 1'b0;
    tick();
    chk_idle("b4_after");

    // Toggled next on 8'h81 (palindrome, same order either way).
    load = 1'b1; in_number = 8'h81;
    tick();
    load = 1'b0;
    acc = 0;
    for (int k = 0; k < 15; k++) begin
      next = (k % 2 == 0);
      chk($sformatf("t81_left%0d", k), 32'(bits_left), 32'(W - acc));
      chk($sformatf("t81_bit%0d", k), 32'(bit_out), 32'(acc == 0 || acc == 7));
      tick();
      if (next) acc++;
    end
    next = 1'b0;
    chk("t81_done", 32'(stream_done), 32'd1);
    tick();
    next = 1'b1;
    tick();
    next = 1'b0;
    chk("idle_next_left", 32'(bits_left), 32'd0);
    chk("idle_next_valid", 32'(bit_valid), 32'd0);

    // Abort 8'hFF after 3 bits with load+next of 8'h0F.
    load = 1'b1; in_number = 8'hFF;
    tick();
    load = 1'b0; next = 1'b1;
    tick(); tick(); tick();
    chk("ff_left3", 32'(bits_left), 32'd5);
    load = 1'b1; in_number = 8'h0F;
    tick();
    load = 1'b0; next = 1'b0;
    chk("abort_left", 32'(bits_left), 32'd8);
    chk("abort_bit", 32'(bit_out), 32'(exp_0f_first));
    chk("abort_nodone", 32'(stream_done), 32'd0);
    next = 1'b1;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("0f_done%0d", i), 32'(stream_done), 32'd0);
      tick();
    end
    next = 1'b0;
    chk("0f_done_pulse", 32'(stream_done), 32'd1);

    // Load accepted in the DONE cycle.
    load = 1'b1; in_number = 8'hB4;
    tick();
    load = 1'b0;
    chk("done_load_valid", 32'(bit_valid), 32'd1);
    chk("done_load_left", 32'(bits_left), 32'd8);
    chk("done_load_pulse", 32'(stream_done), 32'd0);
    chk("done_load_bit", 32'(bit_out), 32'(seq_b4[0]));

    // Reset mid-stream, with load also asserted.
    next = 1'b1;
    tick(); tick();
    chk("mid_left", 32'(bits_left), 32'd6);
    rest = 1'b1; load = 1'b1;
    tick(); tick();
    rest = 1'b0; load = 1'b0; next = 1'b0;
    chk_idle("mid_reset");
    tick();
    chk_idle("post_reset");

    // Wide operand against a bit-indexed reference.
    for (int j = 0; j < BW / 32; j++) big_op[j*32 +: 32] = $urandom;
    b_in = big_op; b_load = 1'b1;
    tick();
    b_load = 1'b0; b_next = 1'b1;
    for (int i = 0; i < BW; i++) begin
`ifdef MSB_FIRST_EN
      chk($sformatf("big_bit%0d", i), 32'(b_bit_out), 32'(big_op[BW-1-i]));
`else
      chk($sformatf("big_bit%0d", i), 32'(b_bit_out), 32'(big_op[i]));
`endif
      if (i % 128 == 0)
        chk($sformatf("big_left%0d", i), 32'(b_bits_left), 32'(BW - i));
      tick();
    end
    b_next = 1'b0;
    chk("big_done", 32'(b_stream_done), 32'd1);
    chk("big_valid", 32'(b_bit_valid), 32'd0);
    tick();
    chk("big_done_clear", 32'(b_stream_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
